// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD seven-segment display scanner.
// Segment vectors are {a,b,c,d,e,f,g}, active low.
package bcd_disp_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'b1111110;

  typedef enum logic [3:0] {
    DC_0     = 4'd0,
    DC_1     = 4'd1,
    DC_2     = 4'd2,
    DC_3     = 4'd3,
    DC_4     = 4'd4,
    DC_5     = 4'd5,
    DC_6     = 4'd6,
    DC_7     = 4'd7,
    DC_8     = 4'd8,
    DC_9     = 4'd9,
    DC_BLANK = 4'd10,
    DC_DASH  = 4'd11
  } digit_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_e;

  // BCD nibbles needed to hold any DATA_W-bit unsigned value.
  function automatic int unsigned bcd_n(input int unsigned data_w);
    return (data_w + 2) / 3;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-code to active-low seven-segment decoder.
// Unused codes decode to blank.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      DC_0:     seg_o = 7'b0000001;
      DC_1:     seg_o = 7'b1001111;
      DC_2:     seg_o = 7'b0010010;
      DC_3:     seg_o = 7'b0000110;
      DC_4:     seg_o = 7'b1001100;
      DC_5:     seg_o = 7'b0100100;
      DC_6:     seg_o = 7'b0100000;
      DC_7:     seg_o = 7'b0001111;
      DC_8:     seg_o = 7'b0000000;
      DC_9:     seg_o = 7'b0000100;
      DC_DASH:  seg_o = SEG_DASH;
      default:  seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD (double-dabble, one shift per clock) converter feeding a
// time-multiplexed common-anode seven-segment display; leftmost digit is the sign.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_LZ    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] value_i,
  input  logic              signed_i,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [6:0]        seg_o,
  output logic              dp_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int unsigned BCD_N = bcd_n(DATA_W);
  localparam int unsigned BCD_W = 4 * BCD_N;
  localparam int unsigned MAX_N = (BCD_N > DIGITS - 1) ? BCD_N : DIGITS - 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);

  state_e                 state_q, state_d;
  logic [DATA_W-1:0]      mag_q, mag_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   neg_q, neg_d;
  logic [CNT_W-1:0]       shift_q, shift_d;
  logic [DIGITS-1:0][3:0] disp_q, disp_d;
  logic                   ovf_q, ovf_d;
  logic [REF_W-1:0]       ref_q, ref_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   lit_q, lit_d;
  seg7_t                  seg_q, seg_d;
  logic [DIGITS-1:0]      an_q, an_d;

  logic [BCD_W-1:0]       bcd_adj;
  logic [4*MAX_N-1:0]     bcd_ext;
  logic [DIGITS-1:0][3:0] commit_disp;
  logic                   commit_ovf;
  logic [3:0]             code_sel;

  assign bcd_ext = (4 * MAX_N)'(bcd_q);

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit codes for a finished conversion; leading-zero scan runs from the
  // most significant shown digit downward and stops at the first nonzero one.
  always_comb begin
    logic        lead;
    logic [3:0]  nib;
    int unsigned pos;
    lead        = (BLANK_LZ != 0);
    nib         = '0;
    pos         = 0;
    commit_ovf  = 1'b0;
    commit_disp = {DIGITS{4'(DC_BLANK)}};
    for (int unsigned i = DIGITS - 1; i < MAX_N; i++) begin
      if (bcd_ext[4*i +: 4] != 4'd0) commit_ovf = 1'b1;
    end
    for (int unsigned j = 0; j < DIGITS - 1; j++) begin
      pos = DIGITS - 2 - j;
      nib = bcd_ext[4*pos +: 4];
      if (lead && nib == 4'd0 && pos != 0) begin
        commit_disp[pos] = 4'(DC_BLANK);
      end else begin
        commit_disp[pos] = nib;
        lead             = 1'b0;
      end
    end
    commit_disp[DIGITS-1] = neg_q ? 4'(DC_DASH) : 4'(DC_BLANK);
    if (commit_ovf) commit_disp = {DIGITS{4'(DC_DASH)}};
  end

  // COMMIT also accepts a new load so a load in the cycle busy_o falls is kept.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    shift_d = shift_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_COMMIT: begin
        if (state_q == ST_COMMIT) begin
          disp_d  = commit_disp;
          ovf_d   = commit_ovf;
          state_d = ST_IDLE;
        end
        if (load_i) begin
          neg_d   = signed_i & value_i[DATA_W-1];
          mag_d   = neg_d ? ('0 - value_i) : value_i;
          bcd_d   = '0;
          shift_d = '0;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        shift_d        = shift_q + 1'b1;
        if (shift_q == CNT_W'(DATA_W - 1)) state_d = ST_COMMIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q;
    idx_d = idx_q;
    lit_d = lit_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      if (!lit_q) begin
        lit_d = 1'b1;
      end else if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else begin
      ref_d = ref_q + 1'b1;
    end
    an_d = '1;
    if (lit_d) an_d[idx_d] = 1'b0;
    code_sel = lit_d ? disp_d[idx_d] : 4'(DC_BLANK);
  end

  seg7_decoder u_dec (
    .code_i (code_sel),
    .seg_o  (seg_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      shift_q <= '0;
      disp_q  <= {DIGITS{4'(DC_BLANK)}};
      ovf_q   <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      lit_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      shift_q <= shift_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      lit_q   <= lit_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy_o = (state_q == ST_CONVERT);
  assign ovf_o  = ovf_q;
  assign seg_o  = seg_q;
  assign dp_o   = 1'b1;
  assign an_o   = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: two scanner instances (8-bit blanked, 10-bit unblanked),
// decimal reference model, per-instance monitors that read back the scanned digits.
module tb_bcd_display_scanner;

  typedef struct packed {
    logic            ovf;
    logic [3:0][6:0] segs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_w   [2];
  logic       signed_w [2];
  logic [7:0] val_a;
  logic [9:0] val_b;
  logic       busy_w   [2];
  logic       ovf_w    [2];
  logic       dp_w     [2];
  logic [6:0] seg_w    [2];
  logic [3:0] an_w     [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.DATA_W(8), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) u_a (
    .clk(clk), .rst_n(rst_n), .load_i(load_w[0]), .value_i(val_a), .signed_i(signed_w[0]),
    .busy_o(busy_w[0]), .ovf_o(ovf_w[0]), .seg_o(seg_w[0]), .dp_o(dp_w[0]), .an_o(an_w[0]));

  bcd_display_scanner #(.DATA_W(10), .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) u_b (
    .clk(clk), .rst_n(rst_n), .load_i(load_w[1]), .value_i(val_b), .signed_i(signed_w[1]),
    .busy_o(busy_w[1]), .ovf_o(ovf_w[1]), .seg_o(seg_w[1]), .dp_o(dp_w[1]), .an_o(an_w[1]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic logic [6:0] dseg(input int unsigned d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      11: return 7'b1111110;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t model(input int unsigned dw, input logic [31:0] v,
                                 input logic s, input bit blz);
    exp_t        e;
    int unsigned m;
    bit          neg;
    neg   = s && v[dw-1];
    m     = neg ? (32'd1 << dw) - v : v;
    e.ovf = (m > 999);
    if (e.ovf) begin
      for (int i = 0; i < 4; i++) e.segs[i] = dseg(11);
    end else begin
      e.segs[0] = dseg(m % 10);
      e.segs[1] = (blz && m < 10)  ? dseg(10) : dseg((m / 10) % 10);
      e.segs[2] = (blz && m < 100) ? dseg(10) : dseg(m / 100);
      e.segs[3] = neg ? dseg(11) : dseg(10);
    end
    return e;
  endfunction

  task automatic issue(input int k, input logic [31:0] v, input logic s, input bit push);
    logic [31:0] vm;
    vm = (k == 0) ? (v & 32'hFF) : (v & 32'h3FF);
    @(negedge clk);
    if (k == 0) val_a = vm[7:0];
    else        val_b = vm[9:0];
    load_w[k]   = 1'b1;
    signed_w[k] = s;
    if (push) begin
      if (k == 0) exp_q0.push_back(model(8, vm, s, 1'b1));
      else        exp_q1.push_back(model(10, vm, s, 1'b0));
    end
    @(negedge clk);
    load_w[k] = 1'b0;
  endtask

  task automatic settle(input int k);
    int t = 0;
    while (busy_w[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("busy_timeout%0d", k), {31'd0, busy_w[k]}, 32'd0);
    repeat (24) @(negedge clk);
  endtask

  task automatic monitor(input int k);
    int unsigned     blen = 0;
    logic            prev = 1'b0;
    int unsigned     dw;
    exp_t            e;
    logic [3:0][6:0] got;
    logic [3:0]      seen;
    logic [3:0]      pat;
    dw = (k == 0) ? 8 : 10;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blen = 0;
        prev = 1'b0;
      end else begin
        if (busy_w[k]) begin
          blen++;
        end else if (prev) begin
          check($sformatf("busy_len%0d", k), blen, dw);
          blen = 0;
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result%0d: result with empty queue, required none", k);
          end else begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            @(negedge clk);
            check($sformatf("ovf%0d", k), {31'd0, ovf_w[k]}, {31'd0, e.ovf});
            seen = '0;
            got  = '1;
            repeat (16) begin
              @(negedge clk);
              for (int d = 0; d < 4; d++) begin
                pat = ~(4'b0001 << d);
                if (an_w[k] == pat) begin
                  got[d]  = seg_w[k];
                  seen[d] = 1'b1;
                end
              end
            end
            check($sformatf("digits_seen%0d", k), {28'd0, seen}, 32'hF);
            for (int d = 0; d < 4; d++)
              check($sformatf("seg%0d_digit%0d", k, d), {25'd0, got[d]}, {25'd0, e.segs[d]});
          end
        end
        prev = busy_w[k];
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [3:0]  exp_an;
    logic [31:0] rv;
    logic        rs;
    int          k;
    load_w[0] = 1'b0; load_w[1] = 1'b0;
    signed_w[0] = 1'b0; signed_w[1] = 1'b0;
    val_a = '0; val_b = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_busy%0d", i), {31'd0, busy_w[i]}, 32'd0);
      check($sformatf("rst_ovf%0d", i), {31'd0, ovf_w[i]}, 32'd0);
      check($sformatf("rst_seg%0d", i), {25'd0, seg_w[i]}, 32'h7F);
      check($sformatf("rst_an%0d", i), {28'd0, an_w[i]}, 32'hF);
      check($sformatf("dp%0d", i), {31'd0, dp_w[i]}, 32'd1);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      exp_an = (c < 4) ? 4'hF : ~(4'b0001 << (((c - 4) / 4) % 4));
      check($sformatf("scan_an_c%0d", c), {28'd0, an_w[0]}, {28'd0, exp_an});
      check($sformatf("scan_seg_c%0d", c), {25'd0, seg_w[0]}, 32'h7F);
      @(negedge clk);
    end

    issue(0, 123, 1'b0, 1'b1);   settle(0);
    issue(0, 8'hFB, 1'b1, 1'b1); settle(0);
    issue(0, 8'h80, 1'b1, 1'b1); settle(0);
    issue(0, 8'h00, 1'b1, 1'b1); settle(0);
    issue(0, 8'h80, 1'b0, 1'b1); settle(0);
    issue(0, 8'hFF, 1'b0, 1'b1); settle(0);
    issue(0, 8'hFF, 1'b1, 1'b1); settle(0);
    issue(0, 8'h7F, 1'b1, 1'b1); settle(0);

    issue(0, 42, 1'b0, 1'b1);
    @(negedge clk);
    issue(0, 77, 1'b0, 1'b0);
    settle(0);

    issue(1, 1023, 1'b0, 1'b1);   settle(1);
    issue(1, 999, 1'b0, 1'b1);    settle(1);
    issue(1, 7, 1'b0, 1'b1);      settle(1);
    issue(1, 10'h200, 1'b1, 1'b1); settle(1);
    issue(1, 10'h3FF, 1'b1, 1'b1); settle(1);

    for (int i = 0; i < 16; i++) begin
      k  = i % 2;
      rv = $urandom;
      rs = 1'($urandom_range(0, 1));
      issue(k, rv, rs, 1'b1);
      settle(k);
    end

    issue(0, 200, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy", {31'd0, busy_w[0]}, 32'd0);
    check("midrst_ovf", {31'd0, ovf_w[0]}, 32'd0);
    check("midrst_an", {28'd0, an_w[0]}, 32'hF);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("midrst_seg_c%0d", c), {25'd0, seg_w[0]}, 32'h7F);
      @(negedge clk);
    end
    issue(0, 200, 1'b0, 1'b1); settle(0);

    check("queue0_empty", exp_q0.size(), 32'd0);
    check("queue1_empty", exp_q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
